// File: rtl/bs_drvr_fifo_if_if.sv
// Bus-driver FIFO bundle: arbiter-side (pndng/pop/push) and node-side (tx/rx) signals.
// slave = the driver itself, master = whatever drives it (arbiter + node, or a bench).
interface bs_drvr_fifo_if_if #(
    parameter int bits  = 256,
    parameter int depth = 16
);
    localparam int cw = $clog2(depth) + 1;

    logic            pndng;
    logic            pop;
    logic [bits-1:0] D_pop;
    logic            push;
    logic [bits-1:0] D_push;

    logic            tx_wr;
    logic [bits-1:0] tx_data;
    logic            tx_full;
    logic            rx_rd;
    logic [bits-1:0] rx_data;
    logic            rx_vld;

    logic [cw-1:0]   tx_cnt;
    logic [cw-1:0]   rx_cnt;
    logic [15:0]     rx_drop_cnt;

    modport slave (
        input  pop, push, D_push, tx_wr, tx_data, rx_rd,
        output pndng, D_pop, tx_full, rx_data, rx_vld, tx_cnt, rx_cnt, rx_drop_cnt
    );

    modport master (
        output pop, push, D_push, tx_wr, tx_data, rx_rd,
        input  pndng, D_pop, tx_full, rx_data, rx_vld, tx_cnt, rx_cnt, rx_drop_cnt
    );
endinterface

// File: rtl/bs_drvr_fifo_if.sv
// Bus driver with a TX FIFO toward the arbiter and an RX FIFO toward the node (both FWFT).
// Define DRVR_ID_FILTER_EN to accept only pushed words addressed to id or broadcast.
module bs_drvr_fifo_if #(
    parameter int         bits      = 256,
    parameter int         depth     = 16,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    bs_drvr_fifo_if_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

`ifdef DRVR_ID_FILTER_EN
    localparam bit filter_en = 1'b1;
`else
    localparam bit filter_en = 1'b0;
`endif

    // ---------------- TX queue ----------------
    logic [bits-1:0] tx_mem [depth];
    logic [aw-1:0]   tx_wp, tx_rp;
    logic [cw-1:0]   tx_cnt_q;
    logic            tx_acc, tx_adv;

    assign bus.tx_full = (tx_cnt_q == cw'(depth));
    assign bus.pndng   = (tx_cnt_q != '0);
    assign bus.D_pop   = tx_mem[tx_rp];
    assign bus.tx_cnt  = tx_cnt_q;

    // Full/empty come from pre-edge occupancy, so a pop never makes room for a same-cycle write.
    assign tx_acc = reset & bus.tx_wr & ~bus.tx_full;
    assign tx_adv = reset & bus.pop & bus.pndng;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_acc) tx_wp <= tx_wp + 1'b1;
            if (tx_adv) tx_rp <= tx_rp + 1'b1;
            case ({tx_acc, tx_adv})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_acc) tx_mem[tx_wp] <= bus.tx_data;
    end

    // ---------------- RX queue ----------------
    logic [bits-1:0] rx_mem [depth];
    logic [aw-1:0]   rx_wp, rx_rp;
    logic [cw-1:0]   rx_cnt_q;
    logic [15:0]     drop_q;
    logic [7:0]      addr;
    logic            addr_ok, rx_full, rx_acc, rx_adv, rx_drop;

    assign addr    = bus.D_push[bits-1 -: 8];
    assign addr_ok = !filter_en || (addr == id) || (addr == broadcast);

    assign rx_full         = (rx_cnt_q == cw'(depth));
    assign bus.rx_vld      = (rx_cnt_q != '0);
    assign bus.rx_data     = rx_mem[rx_rp];
    assign bus.rx_cnt      = rx_cnt_q;
    assign bus.rx_drop_cnt = drop_q;

    assign rx_acc  = reset & bus.push & addr_ok & ~rx_full;
    assign rx_drop = reset & bus.push & addr_ok &  rx_full;
    assign rx_adv  = reset & bus.rx_rd & bus.rx_vld;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt_q <= '0;
            drop_q   <= '0;
        end else begin
            if (rx_acc) rx_wp <= rx_wp + 1'b1;
            if (rx_adv) rx_rp <= rx_rp + 1'b1;
            case ({rx_acc, rx_adv})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            if (rx_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_acc) rx_mem[rx_wp] <= bus.D_push;
    end
endmodule

// File: tb/tb_bs_drvr_fifo_if.sv
// Directed bench for bs_drvr_fifo_if: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_bs_drvr_fifo_if;
    localparam int         BITS  = 256;
    localparam int         DEPTH = 16;
    localparam logic [7:0] ID    = 8'h02;

    typedef logic [BITS-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bs_drvr_fifo_if_if #(.bits(BITS), .depth(DEPTH)) bus ();

    bs_drvr_fifo_if #(.bits(BITS), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t mkw(input logic [7:0] addr, input int n);
        return {addr, 216'h0, 32'(n)};
    endfunction

    // ---------------- reference model ----------------
    word_t txq[$];
    word_t rxq[$];
    int    mdrop;
    bit    m_tf, m_rf, m_ok;

    always @(posedge clk) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            mdrop = 0;
        end else begin
            m_tf = (txq.size() == DEPTH);
            m_rf = (rxq.size() == DEPTH);
            if (bus.pop && txq.size() != 0) void'(txq.pop_front());
            if (bus.tx_wr && !m_tf) txq.push_back(bus.tx_data);
`ifdef DRVR_ID_FILTER_EN
            m_ok = (bus.D_push[BITS-1 -: 8] == ID) || (bus.D_push[BITS-1 -: 8] == 8'hFF);
`else
            m_ok = 1'b1;
`endif
            if (bus.rx_rd && rxq.size() != 0) void'(rxq.pop_front());
            if (bus.push && m_ok) begin
                if (!m_rf) rxq.push_back(bus.D_push);
                else if (mdrop < 65535) mdrop++;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pndng",       BITS'(bus.pndng),       BITS'(txq.size() != 0));
            check("tx_full",     BITS'(bus.tx_full),     BITS'(txq.size() == DEPTH));
            check("tx_cnt",      BITS'(bus.tx_cnt),      BITS'(txq.size()));
            check("rx_vld",      BITS'(bus.rx_vld),      BITS'(rxq.size() != 0));
            check("rx_cnt",      BITS'(bus.rx_cnt),      BITS'(rxq.size()));
            check("rx_drop_cnt", BITS'(bus.rx_drop_cnt), BITS'(mdrop));
            if (txq.size() != 0) check("D_pop",   bus.D_pop,   txq[0]);
            if (rxq.size() != 0) check("rx_data", bus.rx_data, rxq[0]);
        end
    end

    // Advance one clock; returns at the following falling edge with outputs settled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.tx_wr   = 1'b0;
        bus.pop     = 1'b0;
        bus.push    = 1'b0;
        bus.rx_rd   = 1'b0;
        bus.tx_data = '0;
        bus.D_push  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        chk_en = 1'b1;
        check("rst_tx_cnt", BITS'(bus.tx_cnt), '0);
        check("rst_pndng",  BITS'(bus.pndng),  '0);
        check("rst_rx_vld", BITS'(bus.rx_vld), '0);

        // Three writes then three pops
        bus.tx_wr = 1'b1; bus.tx_data = mkw(8'h00, 32'hA);
        cyc();
        check("lit_pndng_after_A", BITS'(bus.pndng), BITS'(1));
        check("lit_dpop_A", bus.D_pop, mkw(8'h00, 32'hA));
        bus.tx_data = mkw(8'h00, 32'hB);
        cyc();
        bus.tx_data = mkw(8'h00, 32'hC);
        cyc();
        bus.tx_wr = 1'b0;
        check("lit_tx_cnt_3", BITS'(bus.tx_cnt), BITS'(3));
        bus.pop = 1'b1;
        cyc();
        check("lit_dpop_B", bus.D_pop, mkw(8'h00, 32'hB));
        cyc();
        check("lit_dpop_C", bus.D_pop, mkw(8'h00, 32'hC));
        cyc();
        bus.pop = 1'b0;
        check("lit_pndng_0", BITS'(bus.pndng), '0);
        // Pop on empty queue is ignored
        bus.pop = 1'b1;
        cyc();
        bus.pop = 1'b0;
        check("lit_pop_empty", BITS'(bus.tx_cnt), '0);

        // Fill TX, then write+pop while full
        bus.tx_wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.tx_data = mkw(8'h00, 100 + i);
            cyc();
        end
        check("lit_tx_full", BITS'(bus.tx_full), BITS'(1));
        bus.tx_data = mkw(8'h00, 999);
        bus.pop = 1'b1;
        cyc();
        idle();
        check("lit_tx_cnt_15", BITS'(bus.tx_cnt), BITS'(15));
        check("lit_dpop_101", bus.D_pop, mkw(8'h00, 101));
        bus.pop = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        bus.pop = 1'b0;
        check("lit_tx_drained", BITS'(bus.pndng), '0);

        // Fill RX, overflow by three, read back in order
        bus.push = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.D_push = mkw(ID, 200 + i);
            cyc();
        end
        idle();
        check("lit_rx_cnt_16", BITS'(bus.rx_cnt), BITS'(16));
        check("lit_drop_3", BITS'(bus.rx_drop_cnt), BITS'(3));
        for (int i = 0; i < DEPTH; i++) begin
            check("lit_rx_order", bus.rx_data, mkw(ID, 200 + i));
            bus.rx_rd = 1'b1;
            cyc();
        end
        bus.rx_rd = 1'b0;
        check("lit_rx_empty", BITS'(bus.rx_vld), '0);

        // Address filter
        do_reset();
        bus.push = 1'b1;
        bus.D_push = mkw(8'h02, 1); cyc();
        bus.D_push = mkw(8'h05, 2); cyc();
        bus.D_push = mkw(8'hFF, 3); cyc();
        idle();
`ifdef DRVR_ID_FILTER_EN
        check("lit_filter_rx_cnt", BITS'(bus.rx_cnt), BITS'(2));
`else
        check("lit_filter_rx_cnt", BITS'(bus.rx_cnt), BITS'(3));
`endif
        check("lit_filter_drop", BITS'(bus.rx_drop_cnt), '0);
        bus.rx_rd = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        bus.rx_rd = 1'b0;

        // Mid-operation reset with strobes high
        bus.tx_wr = 1'b1;
        bus.push  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.tx_data = mkw(8'h00, 300 + i);
            bus.D_push  = mkw(ID, 400 + i);
            cyc();
        end
        check("lit_pre_rst_tx", BITS'(bus.tx_cnt), BITS'(5));
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        idle();
        check("lit_mrst_tx_cnt", BITS'(bus.tx_cnt), '0);
        check("lit_mrst_rx_cnt", BITS'(bus.rx_cnt), '0);
        check("lit_mrst_pndng",  BITS'(bus.pndng),  '0);
        check("lit_mrst_rx_vld", BITS'(bus.rx_vld), '0);

        // Half-full queue, 40 cycles of simultaneous write and pop across pointer wrap
        bus.tx_wr = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            bus.tx_data = mkw(8'h00, 500 + i);
            cyc();
        end
        bus.pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.tx_data = mkw(8'h00, 600 + i);
            cyc();
            check("lit_steady_cnt", BITS'(bus.tx_cnt), BITS'(DEPTH / 2));
        end
        check("lit_steady_head", bus.D_pop, mkw(8'h00, 600 + 40 - DEPTH / 2));
        bus.tx_wr = 1'b0;
        for (int i = 0; i < DEPTH / 2; i++) cyc();
        idle();
        cyc();
        check("lit_end_empty", BITS'(bus.pndng), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
